// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_if
// Description : Control, program-loader, instruction-memory and decode
//               handshake bundle for the instruction fetch sequencer.
//               master = the sequencer, slave = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              halt_req;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              busy;
    logic              halted;

    modport master (
        input  start, start_addr, halt_req, redirect_valid, redirect_addr,
               ld_valid, ld_addr, ld_data, mem_rdata, instr_ready,
        output ld_ready, mem_addr, mem_we, mem_wdata,
               instr_valid, instr_data, instr_pc, busy, halted
    );

    modport slave (
        output start, start_addr, halt_req, redirect_valid, redirect_addr,
               ld_valid, ld_addr, ld_data, mem_rdata, instr_ready,
        input  ld_ready, mem_addr, mem_we, mem_wdata,
               instr_valid, instr_data, instr_pc, busy, halted
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction fetch sequencer. Issues reads to a registered
//               instruction memory, buffers responses in a 2-entry FIFO and
//               hands them to decode; supports redirect, orderly halt and a
//               program-loader write port while stopped.
//               Optional macro FETCH_ZERO_HALT_EN: an all-zero fetched word
//               is discarded and fetch drains to HALTED.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 64
) (
    input wire                clk,
    input wire                rst,
    fetch_sequencer_if.master bus
);
    localparam int ADDR_W = $clog2(MEM_DEPTH);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_DRAIN  = 2'd2;
    localparam logic [1:0] c_ST_HALTED = 2'd3;

    localparam logic [ADDR_W-1:0] c_PC_LAST = ADDR_W'(MEM_DEPTH - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_fifo_data0, r_fifo_data1;
    logic [ADDR_W-1:0] r_fifo_pc0, r_fifo_pc1;

    logic              w_stopped, w_ld_ready, w_load, w_pop;
    logic              w_run, w_run_cmd, w_redir, w_zero_stop, w_resp_keep;
    logic              w_room, w_issue;
    logic [2:0]        w_occ;
    logic [1:0]        w_cnt_pop, w_cnt_nxt;
    logic [DATA_W-1:0] w_data0_nxt, w_data1_nxt;
    logic [ADDR_W-1:0] w_pc0_nxt, w_pc1_nxt;

    // Wrapping increment so non-power-of-two depths also return to 0.
    function automatic logic [ADDR_W-1:0] f_pc_inc(input logic [ADDR_W-1:0] pc);
        return (pc == c_PC_LAST) ? '0 : pc + 1'b1;
    endfunction

    // Loader is only accepted while stopped; start takes priority over it.
    assign w_stopped  = (r_state == c_ST_IDLE) || (r_state == c_ST_HALTED);
    assign w_ld_ready = !rst && w_stopped && !bus.start;
    assign w_load     = bus.ld_valid && w_ld_ready;
    assign w_pop      = (r_count != 2'd0) && bus.instr_ready;

    // halt_req beats redirect; redirect kills the response arriving now.
    assign w_run      = !rst && (r_state == c_ST_RUN);
    assign w_run_cmd  = w_run && !bus.halt_req && !bus.redirect_valid;
    assign w_redir    = w_run && bus.redirect_valid && !bus.halt_req;

`ifdef FETCH_ZERO_HALT_EN
    assign w_zero_stop = w_run_cmd && r_inflight && (bus.mem_rdata == '0);
`else
    assign w_zero_stop = 1'b0;
`endif

    assign w_resp_keep = w_run_cmd && r_inflight && !w_zero_stop;

    // Issue only if the FIFO can absorb everything already outstanding.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_room  = (w_occ < 3'd2);
    assign w_issue = w_run_cmd && !w_zero_stop && w_room;

    // Redirect target is issued in the same cycle to hide one cycle of latency.
    assign bus.mem_we      = w_load;
    assign bus.mem_wdata   = w_load ? bus.ld_data : '0;
    assign bus.mem_addr    = w_load  ? bus.ld_addr :
                             w_redir ? bus.redirect_addr :
                             w_issue ? r_pc : '0;

    assign bus.ld_ready    = w_ld_ready;
    assign bus.instr_valid = (r_count != 2'd0);
    assign bus.instr_data  = r_fifo_data0;
    assign bus.instr_pc    = r_fifo_pc0;
    assign bus.busy        = (r_state == c_ST_RUN) || (r_state == c_ST_DRAIN);
    assign bus.halted      = (r_state == c_ST_HALTED);

    // Shift-style FIFO next state: pop moves entry 1 to the head, then a
    // surviving response lands in the first free slot.
    always_comb begin
        w_cnt_pop   = r_count - {1'b0, w_pop};
        w_data0_nxt = r_fifo_data0;
        w_data1_nxt = r_fifo_data1;
        w_pc0_nxt   = r_fifo_pc0;
        w_pc1_nxt   = r_fifo_pc1;
        if (w_pop) begin
            w_data0_nxt = r_fifo_data1;
            w_pc0_nxt   = r_fifo_pc1;
        end
        if (w_resp_keep) begin
            if (w_cnt_pop == 2'd0) begin
                w_data0_nxt = bus.mem_rdata;
                w_pc0_nxt   = r_inflight_pc;
            end else begin
                w_data1_nxt = bus.mem_rdata;
                w_pc1_nxt   = r_inflight_pc;
            end
        end
        w_cnt_nxt = w_cnt_pop + {1'b0, w_resp_keep};
    end

    // Sequencer FSM, program counter, in-flight tracking and FIFO storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_pc          <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_count       <= 2'd0;
            r_fifo_data0  <= '0;
            r_fifo_data1  <= '0;
            r_fifo_pc0    <= '0;
            r_fifo_pc1    <= '0;
        end else begin
            r_fifo_data0 <= w_data0_nxt;
            r_fifo_data1 <= w_data1_nxt;
            r_fifo_pc0   <= w_pc0_nxt;
            r_fifo_pc1   <= w_pc1_nxt;
            r_count      <= w_cnt_nxt;
            case (r_state)
                c_ST_IDLE, c_ST_HALTED: begin
                    if (bus.start) begin
                        r_pc       <= bus.start_addr;
                        r_count    <= 2'd0;
                        r_inflight <= 1'b0;
                        r_state    <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (bus.halt_req) begin
                        r_inflight <= 1'b0;
                        r_state    <= c_ST_DRAIN;
                    end else if (bus.redirect_valid) begin
                        r_count       <= 2'd0;
                        r_inflight    <= 1'b1;
                        r_inflight_pc <= bus.redirect_addr;
                        r_pc          <= f_pc_inc(bus.redirect_addr);
                    end else if (w_zero_stop) begin
                        r_inflight <= 1'b0;
                        r_state    <= c_ST_DRAIN;
                    end else begin
                        r_inflight <= w_issue;
                        if (w_issue) begin
                            r_inflight_pc <= r_pc;
                            r_pc          <= f_pc_inc(r_pc);
                        end
                    end
                end
                c_ST_DRAIN: begin
                    if (w_cnt_nxt == 2'd0) begin
                        r_state <= c_ST_HALTED;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed self-checking bench for fetch_sequencer with a
//               registered-read instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_sequencer_if #(.DATA_W(32), .ADDR_W(6)) bus ();

    fetch_sequencer #(.DATA_W(32), .MEM_DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:63];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: write-through loader port, one-cycle registered read.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    function automatic logic [31:0] exp_data(input int a);
        return (a == 6) ? 32'h0 : (32'hC0DE_0000 | 32'(a));
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 0; bus.start_addr = '0; bus.halt_req = 0;
        bus.redirect_valid = 0; bus.redirect_addr = '0;
        bus.ld_valid = 0; bus.ld_addr = '0; bus.ld_data = '0;
        bus.instr_ready = 0;

        // Reset state
        tick(); tick(); #1;
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_ld_ready", bus.ld_ready, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_instr_pc", bus.instr_pc, 0);
        chk("rst_instr_data", bus.instr_data, 0);
        tick(); rst = 0; #1;
        chk("idle_ld_ready", bus.ld_ready, 1);

        // Load all 64 words; word 6 is zero
        for (int i = 0; i < 64; i++) begin
            bus.ld_valid = 1; bus.ld_addr = 6'(i); bus.ld_data = exp_data(i); #1;
            if (i == 5) begin
                chk("ld_mem_we", bus.mem_we, 1);
                chk("ld_mem_addr", bus.mem_addr, 5);
                chk("ld_mem_wdata", bus.mem_wdata, exp_data(5));
            end
            tick();
        end

        // start beats a concurrent loader write (would corrupt word 6)
        bus.start = 1; bus.start_addr = 0;
        bus.ld_valid = 1; bus.ld_addr = 6; bus.ld_data = 32'hFFFF_FFFF; #1;
        chk("start_ld_ready", bus.ld_ready, 0);
        chk("start_mem_we", bus.mem_we, 0);
        tick();
        bus.start = 0; bus.ld_valid = 0; bus.instr_ready = 1; #1;
        chk("run1_busy", bus.busy, 1);
        chk("run1_valid", bus.instr_valid, 0);
        chk("run1_mem_addr", bus.mem_addr, 0);
        tick(); #1;
        chk("run2_valid", bus.instr_valid, 0);
        chk("run2_mem_addr", bus.mem_addr, 1);
        tick();
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("seq_valid", bus.instr_valid, 1);
            chk("seq_pc", bus.instr_pc, 64'(k));
            chk("seq_data", bus.instr_data, exp_data(k));
            tick();
        end
`ifdef FETCH_ZERO_HALT_EN
        #1;
        chk("zh_valid", bus.instr_valid, 0);
        chk("zh_busy", bus.busy, 1);
        tick(); #1;
        chk("zh_halted", bus.halted, 1);
        chk("zh_ld_ready", bus.ld_ready, 1);
        chk("zh_busy_off", bus.busy, 0);
`else
        bus.halt_req = 1; #1;
        chk("zero_valid", bus.instr_valid, 1);
        chk("zero_pc", bus.instr_pc, 6);
        chk("zero_data", bus.instr_data, 0);
        tick(); bus.halt_req = 0; #1;
        chk("drain_valid", bus.instr_valid, 0);
        chk("drain_busy", bus.busy, 1);
        chk("drain_halted", bus.halted, 0);
        tick(); #1;
        chk("halt_halted", bus.halted, 1);
        chk("halt_busy", bus.busy, 0);
        chk("halt_ld_ready", bus.ld_ready, 1);
`endif

        // Backpressure: 5 stalled cycles mid-stream from addr 10
        bus.start = 1; bus.start_addr = 10; bus.instr_ready = 1;
        tick(); bus.start = 0;
        tick(); tick(); #1;
        chk("bp_pc10", bus.instr_pc, 10);
        tick(); #1;
        chk("bp_pc11", bus.instr_pc, 11);
        tick(); bus.instr_ready = 0;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("bp_hold_valid", bus.instr_valid, 1);
            chk("bp_hold_pc", bus.instr_pc, 12);
            chk("bp_hold_data", bus.instr_data, exp_data(12));
            tick();
        end
        bus.instr_ready = 1;
        for (int j = 12; j < 16; j++) begin
            #1;
            chk("bp_resume_pc", bus.instr_pc, 64'(j));
            chk("bp_resume_data", bus.instr_data, exp_data(j));
            tick();
        end
        // halt_req with redirect in the same cycle: halt wins
        bus.halt_req = 1; bus.redirect_valid = 1; bus.redirect_addr = 50; #1;
        chk("hr_pc16", bus.instr_pc, 16);
        chk("hr_no_issue", bus.mem_addr, 0);
        tick(); bus.halt_req = 0; bus.redirect_valid = 0; #1;
        chk("hr_valid", bus.instr_valid, 0);
        chk("hr_busy", bus.busy, 1);
        chk("hr_mem_addr", bus.mem_addr, 0);
        tick(); #1;
        chk("hr_halted", bus.halted, 1);

        // Redirect to 40 while pc=3, with a pop in the same cycle
        bus.start = 1; bus.start_addr = 0;
        tick(); bus.start = 0;
        tick(); tick(); #1;
        chk("rd_pc0", bus.instr_pc, 0);
        tick(); bus.redirect_valid = 1; bus.redirect_addr = 40; #1;
        chk("rd_pc1", bus.instr_pc, 1);
        chk("rd_issue40", bus.mem_addr, 40);
        tick(); bus.redirect_valid = 0; #1;
        chk("rd_flushed", bus.instr_valid, 0);
        tick(); #1;
        chk("rd_pc40", bus.instr_pc, 40);
        chk("rd_data40", bus.instr_data, exp_data(40));
        tick(); #1;
        chk("rd_pc41", bus.instr_pc, 41);
        tick(); bus.halt_req = 1;
        tick(); bus.halt_req = 0;
        tick(); #1;
        chk("rd_halted", bus.halted, 1);

        // Wrap: start at 62
        bus.start = 1; bus.start_addr = 62;
        tick(); bus.start = 0;
        tick(); tick(); #1;
        chk("wr_pc62", bus.instr_pc, 62);
        chk("wr_issue0", bus.mem_addr, 0);
        tick(); #1;
        chk("wr_pc63", bus.instr_pc, 63);
        tick(); #1;
        chk("wr_pc0", bus.instr_pc, 0);
        chk("wr_data0", bus.instr_data, exp_data(0));
        tick(); #1;
        chk("wr_pc1", bus.instr_pc, 1);
        tick(); bus.instr_ready = 0; #1;
        chk("pre_rst_valid", bus.instr_valid, 1);
        chk("pre_rst_pc", bus.instr_pc, 2);

        // Reset with buffered word and read in flight; all other inputs active
        rst = 1; bus.start = 1; bus.start_addr = 9; bus.halt_req = 1;
        bus.redirect_valid = 1; bus.redirect_addr = 20;
        bus.ld_valid = 1; bus.ld_addr = 3; bus.ld_data = 32'h1234; #1;
        chk("midrst_mem_we", bus.mem_we, 0);
        chk("midrst_ld_ready", bus.ld_ready, 0);
        tick();
        rst = 0; bus.start = 0; bus.halt_req = 0; bus.redirect_valid = 0;
        bus.ld_valid = 0; #1;
        chk("post_rst_valid", bus.instr_valid, 0);
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_halted", bus.halted, 0);
        chk("post_rst_idle", bus.ld_ready, 1);
        chk("post_rst_pc", dut.r_pc, 0);
        chk("post_rst_instr_pc", bus.instr_pc, 0);
        chk("post_rst_instr_data", bus.instr_data, 0);
        chk("post_rst_mem_addr", bus.mem_addr, 0);
        tick(); #1;
        chk("post_rst_killed", bus.instr_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-002 SHALL have parameter MEM_DEPTH, default 64, meaning instruction memory words; ADDR_W = $clog2(MEM_DEPTH).
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports start / start_addr  input  1 / ADDR_W  begin fetching at start_addr.
REQ-006 SHALL have port halt_req  input  1  request orderly stop.
REQ-007 SHALL have ports redirect_valid / redirect_addr  input  1 / ADDR_W  branch/jump target from decode.
REQ-008 SHALL have ports ld_valid, ld_addr, ld_data / ld_ready  input 1, ADDR_W, DATA_W / output 1  program-loader write port.
REQ-009 SHALL have ports mem_addr, mem_we, mem_wdata / mem_rdata  output ADDR_W, 1, DATA_W / input DATA_W  instruction memory port; mem_rdata is registered, valid the cycle after mem_addr presented.
REQ-010 SHALL have ports instr_valid, instr_data, instr_pc / instr_ready  output 1, DATA_W, ADDR_W / input 1  decode handshake.
REQ-011 SHALL have ports busy, halted  output 1, 1  status.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DRAIN, HALTED.
REQ-013 IDLE/HALTED: start=1 -> pc<=start_addr, FIFO and in-flight cleared, RUN next cycle.
REQ-014 ld_ready SHALL be 1 only in IDLE or HALTED with start=0; start wins over ld_valid in the same cycle.
REQ-015 When ld_valid&ld_ready: mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data, combinationally; otherwise mem_we=0.
REQ-016 RUN: SHALL issue read mem_addr=pc, pc<=pc+1 modulo MEM_DEPTH (MEM_DEPTH-1 wraps to 0), when occupancy + in_flight - pop < 2.
REQ-017 SHALL hold a 2-entry output FIFO of {data, pc}; response written the cycle after issue; pop when instr_valid&instr_ready.
REQ-018 instr_valid SHALL equal FIFO non-empty; instr_data/instr_pc SHALL be head entry, stable while instr_valid&!instr_ready.
REQ-019 Sustained instr_ready=1 SHALL yield one instruction per cycle; first instr_valid 2 cycles after entering RUN.
REQ-020 redirect_valid in RUN SHALL flush FIFO, kill in-flight response, set pc<=redirect_addr; first redirected instruction valid 2 cycles later; ignored outside RUN.
REQ-021 redirect_valid and a pop in the same cycle: pop completes, then flush.
REQ-022 halt_req in RUN SHALL stop issue, kill in-flight, enter DRAIN; DRAIN -> HALTED when FIFO empty after final pop.
REQ-023 redirect_valid and halt_req together: halt_req wins, redirect ignored.
REQ-024 busy SHALL be 1 in RUN and DRAIN; halted SHALL be 1 in HALTED.

Reset
REQ-025 rst SHALL force IDLE, pc=0, FIFO empty, in-flight killed, instr_valid=0, instr_data=0, instr_pc=0, mem_we=0, mem_addr=0, mem_wdata=0, ld_ready=0, busy=0, halted=0.
REQ-026 rst mid-operation SHALL take precedence over every other input in that cycle.

Configuration
REQ-027 Macro FETCH_ZERO_HALT_EN defined: an all-zero fetched word SHALL be discarded (not written to FIFO), issue stops, further in-flight killed, FSM enters DRAIN.
REQ-028 Macro FETCH_ZERO_HALT_EN undefined: all-zero words SHALL be delivered as normal instructions; only halt_req stops fetch.

Verification
REQ-029 Load 6 words at 0..5 via loader, start start_addr=0, instr_ready=1 -> instr_pc 0,1,2,3,4,5 on consecutive cycles, first valid 2 cycles after RUN.
REQ-030 instr_ready=0 for 5 cycles mid-stream -> no word lost/duplicated, instr_data/instr_pc held, FIFO never exceeds 2.
REQ-031 Redirect to addr 40 while pc=3 -> no stale words delivered, next instr_pc=40 two cycles later.
REQ-032 start_addr=62, MEM_DEPTH=64 -> instr_pc 62,63,0,1.
REQ-033 With FETCH_ZERO_HALT_EN, word 6 = 0 -> last delivered instr_pc=5, then halted=1, ld_ready=1; without macro instr_pc=6 delivered with data 0.
REQ-034 rst asserted with FIFO full and read in flight -> next cycle instr_valid=0, busy=0, state IDLE, pc=0.
